// File: rtl/jk_seq_ctrl.sv
// rtl/jk_seq_ctrl.sv - sequence controller whose state lives in a JK flip-flop bank
//
// Purpose: runs an up, down, Gray or hold sequence from the current Q until Q
// reaches a latched target. Every change of Q goes through a WIDTH-bit JK bank
// driven by minimal J/K excitation. A run that has not reached the target after
// 2^WIDTH steps is aborted.
//
// Ports:
//   Clk      - clock, rising edge
//   RST_B    - asynchronous active-low reset
//   start    - request a run (sampled in IDLE)
//   mode     - 00 up, 01 down, 10 Gray, 11 hold (latched on start)
//   load     - parallel load of load_val (sampled in IDLE, wins over start)
//   load_val - parallel load value
//   target   - terminal value for a run (latched on start)
//   J, K     - per-bit excitation into the JK bank
//   Q        - JK bank state
//   busy     - high while in RUN
//   done     - one-cycle pulse when a run reaches its target
//   err      - one-cycle pulse when a run hits the step limit
module jk_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             RST_B,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // The run aborts on the step that brings the count to 2^WIDTH.
  localparam logic [WIDTH:0] STEP_LIMIT = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] CNT_ONE    = {{WIDTH{1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [WIDTH:0]   step_cnt, step_cnt_nxt;
  logic [1:0]       mode_l;
  logic [WIDTH-1:0] target_l;
  logic             latch_en;
  logic [WIDTH-1:0] want;      // desired next value of Q
  logic [WIDTH-1:0] step_val;  // successor of Q under the latched mode
  logic [WIDTH-1:0] gray_bin;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    step_val = Q;
    gray_bin = gray2bin(Q) + WIDTH'(1);
    case (mode_l)
      2'b00:   step_val = Q + WIDTH'(1);
      2'b01:   step_val = Q - WIDTH'(1);
      2'b10:   step_val = gray_bin ^ (gray_bin >> 1);
      default: step_val = Q;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    step_cnt_nxt = step_cnt;
    want         = Q;
    latch_en     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (state)
      IDLE: begin
        // Qualified by RST_B so a held load cannot excite the bank during reset.
        if (RST_B) begin
          if (load) begin
            want = load_val;
          end else if (start) begin
            latch_en     = 1'b1;
            step_cnt_nxt = '0;
            state_nxt    = RUN;
          end
        end
      end
      RUN: begin
        busy         = 1'b1;
        want         = step_val;
        step_cnt_nxt = step_cnt + CNT_ONE;
        // Target match takes priority over the step limit on the same step.
        if (step_val == target_l) begin
          state_nxt = DONE;
        end else if (step_cnt_nxt == STEP_LIMIT) begin
          state_nxt = ERR;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        err       = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Minimal excitation: J and K are never both high.
    J = ~Q & want;
    K = Q & ~want;
  end

  always_ff @(posedge Clk or negedge RST_B) begin
    if (!RST_B) begin
      state    <= IDLE;
      Q        <= '0;
      step_cnt <= '0;
      mode_l   <= 2'b00;
      target_l <= '0;
    end else begin
      state    <= state_nxt;
      Q        <= (J & ~Q) | (~K & Q);
      step_cnt <= step_cnt_nxt;
      if (latch_en) begin
        mode_l   <= mode;
        target_l <= target;
      end
    end
  end

endmodule
